// File: rtl/mano_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mano_control_sequencer
// Description : Timing-and-control unit for the 8-bit accumulator computer.
//               Steps the fetch/decode/execute sequence, issues register-load
//               and memory strobes, and stalls on memory wait states. A stall
//               that runs past WAIT_MAX cycles aborts to IDLE with bus_err set.
//               It also reports run/halt status and counts retired
//               instructions.
// Ports       : clock, reset_n          - clock, async active-low reset
//               start                   - begin execution (IDLE only)
//               ir_opcode, acc_zero     - decode inputs from the datapath
//               mem_ready               - memory handshake
//               ar_load_pc .. acc_op    - datapath/memory strobes (comb.)
//               t_state, busy           - sequence position / running flag
//               halted, bus_err         - sticky status
//               insn_count              - retired instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module mano_control_sequencer #(
    parameter int CNT_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       ir_opcode,
    input  logic             acc_zero,
    input  logic             mem_ready,
    output logic             ar_load_pc,
    output logic             ar_load_ir,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_load,
    output logic             dr_load,
    output logic             acc_load,
    output logic [1:0]       acc_op,
    output logic [2:0]       t_state,
    output logic             busy,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] insn_count
);

    // State encoding doubles as the T-state output value.
    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_DEC  = 3'd2,
        S_E0   = 3'd3,
        S_E1   = 3'd4,
        S_IDLE = 3'd7
    } state_t;

    localparam logic [2:0] c_op_lda = 3'b000;
    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_sta = 3'b011;
    localparam logic [2:0] c_op_jmp = 3'b100;
    localparam logic [2:0] c_op_bz  = 3'b101;
    localparam logic [2:0] c_op_cma = 3'b110;
    localparam logic [2:0] c_op_hlt = 3'b111;

    localparam int                c_wait_w   = $clog2(WAIT_MAX + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(WAIT_MAX);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_halted;
    logic                r_bus_err;
    logic [CNT_W-1:0]    r_insn_count;

    logic                w_retire;
    logic                w_timeout;
    logic                w_wait_inc;
    logic                w_halt_set;
    logic                w_start_go;

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        ar_load_pc   = 1'b0;
        ar_load_ir   = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        ir_load      = 1'b0;
        dr_load      = 1'b0;
        acc_load     = 1'b0;
        acc_op       = 2'b00;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        w_wait_inc   = 1'b0;
        w_halt_set   = 1'b0;
        w_start_go   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_go   = 1'b1;
                    w_state_next = S_F0;
                end
            end
            S_F0: begin
                ar_load_pc   = 1'b1;
                w_state_next = S_F1;
            end
            S_F1: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = S_DEC;
                end else if (r_wait_cnt == c_wait_max) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_DEC: begin
                // Opcodes with IR[7]=0 are memory-reference and need an
                // execute phase; everything else retires here.
                if (!ir_opcode[2]) begin
                    ar_load_ir   = 1'b1;
                    w_state_next = S_E0;
                end else begin
                    w_retire     = 1'b1;
                    w_state_next = S_F0;
                    case (ir_opcode)
                        c_op_jmp: pc_load = 1'b1;
                        c_op_bz:  pc_load = acc_zero;
                        c_op_cma: begin
                            acc_load = 1'b1;
                            acc_op   = 2'b11;
                        end
                        c_op_hlt: begin
                            w_halt_set   = 1'b1;
                            w_state_next = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            S_E0: begin
                if (ir_opcode == c_op_sta) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
                if (mem_ready) begin
                    if (ir_opcode == c_op_sta) begin
                        w_retire     = 1'b1;
                        w_state_next = S_F0;
                    end else begin
                        dr_load      = 1'b1;
                        w_state_next = S_E1;
                    end
                end else if (r_wait_cnt == c_wait_max) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_E1: begin
                acc_load = 1'b1;
                case (ir_opcode)
                    c_op_lda: acc_op = 2'b00;
                    c_op_add: acc_op = 2'b01;
                    c_op_and: acc_op = 2'b10;
                    default:  acc_op = 2'b00;
                endcase
                w_retire     = 1'b1;
                w_state_next = S_F0;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_halted     <= 1'b0;
            r_bus_err    <= 1'b0;
            r_insn_count <= '0;
        end else begin
            r_state <= w_state_next;

            // F0 and DEC are the only predecessors of the wait states, so
            // clearing there gives a fresh count on every entry.
            if (r_state == S_F0 || r_state == S_DEC) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + c_wait_one;
            end

            if (w_start_go) begin
                r_halted  <= 1'b0;
                r_bus_err <= 1'b0;
            end else begin
                if (w_halt_set) begin
                    r_halted <= 1'b1;
                end
                if (w_timeout) begin
                    r_bus_err <= 1'b1;
                end
            end

            if (w_retire) begin
                r_insn_count <= r_insn_count + c_cnt_one;
            end
        end
    end

    assign t_state    = r_state;
    assign busy       = (r_state != S_IDLE);
    assign halted     = r_halted;
    assign bus_err    = r_bus_err;
    assign insn_count = r_insn_count;

endmodule
`default_nettype wire

// File: tb/tb_mano_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mano_control_sequencer
// Description : Self-checking bench for mano_control_sequencer. A table of
//               per-cycle input/expected-output records walks every opcode,
//               followed by hand-written sequences for wait states, timeout,
//               mid-instruction reset and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mano_control_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] ir_opcode;
    logic       acc_zero;
    logic       mem_ready;
    logic       ar_load_pc, ar_load_ir, pc_inc, pc_load, mem_rd, mem_wr;
    logic       ir_load, dr_load, acc_load;
    logic [1:0] acc_op;
    logic [2:0] t_state;
    logic       busy, halted, bus_err;
    logic [7:0] insn_count;

    mano_control_sequencer #(.CNT_W(8), .WAIT_MAX(15)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .ir_opcode  (ir_opcode),
        .acc_zero   (acc_zero),
        .mem_ready  (mem_ready),
        .ar_load_pc (ar_load_pc),
        .ar_load_ir (ar_load_ir),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_load    (ir_load),
        .dr_load    (dr_load),
        .acc_load   (acc_load),
        .acc_op     (acc_op),
        .t_state    (t_state),
        .busy       (busy),
        .halted     (halted),
        .bus_err    (bus_err),
        .insn_count (insn_count)
    );

    always #5 clock = ~clock;

    // Strobe vector order: ar_load_pc ar_load_ir pc_inc pc_load mem_rd
    //                      mem_wr ir_load dr_load acc_load
    localparam logic [8:0] ARPC = 9'b1_0000_0000;
    localparam logic [8:0] ARIR = 9'b0_1000_0000;
    localparam logic [8:0] PCI  = 9'b0_0100_0000;
    localparam logic [8:0] PCL  = 9'b0_0010_0000;
    localparam logic [8:0] RD   = 9'b0_0001_0000;
    localparam logic [8:0] WR   = 9'b0_0000_1000;
    localparam logic [8:0] IRL  = 9'b0_0000_0100;
    localparam logic [8:0] DRL  = 9'b0_0000_0010;
    localparam logic [8:0] ACL  = 9'b0_0000_0001;
    localparam logic [8:0] NONE = 9'b0;
    localparam logic [8:0] FETCH = RD | IRL | PCI;

    typedef struct packed {
        logic [2:0] t;
        logic       busy;
        logic [8:0] stb;
        logic [1:0] op;
        logic       halted;
        logic       berr;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic       st;
        logic [2:0] op;
        logic       az;
        logic       mr;
        exp_t       e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t ex(input logic [2:0] t, input logic [8:0] s,
                                input logic [1:0] op, input logic h,
                                input logic b, input logic [7:0] c);
        exp_t r;
        r.t      = t;
        r.busy   = (t != 3'd7);
        r.stb    = s;
        r.op     = op;
        r.halted = h;
        r.berr   = b;
        r.cnt    = c;
        return r;
    endfunction

    task automatic add(input logic st, input logic [2:0] op, input logic az,
                       input logic mr, input exp_t e);
        vec_t v;
        v.st = st; v.op = op; v.az = az; v.mr = mr; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm);
        exp_t got;
        exp_t e;
        got = {t_state, busy, ar_load_pc, ar_load_ir, pc_inc, pc_load, mem_rd,
               mem_wr, ir_load, dr_load, acc_load, acc_op, halted, bus_err,
               insn_count};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got t=%0d stb=%b", nm, got.t, got.stb);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got t=%0d busy=%b stb=%b op=%b h=%b err=%b cnt=%0d, expected t=%0d busy=%b stb=%b op=%b h=%b err=%b cnt=%0d",
                         nm, got.t, got.busy, got.stb, got.op, got.halted, got.berr, got.cnt,
                         e.t, e.busy, e.stb, e.op, e.halted, e.berr, e.cnt);
            end
        end
    endtask

    // One clock cycle: drive after the rising edge, sample at the falling edge.
    task automatic step(input string nm, input logic rn, input logic st,
                        input logic [2:0] op, input logic az, input logic mr,
                        input exp_t e);
        @(posedge clock);
        #1;
        reset_n   = rn;
        start     = st;
        ir_opcode = op;
        acc_zero  = az;
        mem_ready = mr;
        sb.push_back(e);
        @(negedge clock);
        check(nm);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        ir_opcode = 3'b000;
        acc_zero  = 1'b0;
        mem_ready = 1'b0;

        // Per-cycle records: IDLE start, then every opcode with zero waits.
        add(1, 3'd0, 0, 1, ex(7, NONE, 2'b00, 0, 0, 0));
        add(0, 3'd0, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 0));   // LDA
        add(0, 3'd0, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 0));
        add(0, 3'd0, 0, 1, ex(2, ARIR, 2'b00, 0, 0, 0));
        add(0, 3'd0, 0, 1, ex(3, RD | DRL, 2'b00, 0, 0, 0));
        add(0, 3'd0, 0, 1, ex(4, ACL, 2'b00, 0, 0, 0));
        add(0, 3'd1, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 1));   // ADD
        add(0, 3'd1, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 1));
        add(0, 3'd1, 0, 1, ex(2, ARIR, 2'b00, 0, 0, 1));
        add(0, 3'd1, 0, 1, ex(3, RD | DRL, 2'b00, 0, 0, 1));
        add(0, 3'd1, 0, 1, ex(4, ACL, 2'b01, 0, 0, 1));
        add(0, 3'd2, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 2));   // AND
        add(0, 3'd2, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 2));
        add(0, 3'd2, 0, 1, ex(2, ARIR, 2'b00, 0, 0, 2));
        add(0, 3'd2, 0, 1, ex(3, RD | DRL, 2'b00, 0, 0, 2));
        add(0, 3'd2, 0, 1, ex(4, ACL, 2'b10, 0, 0, 2));
        add(0, 3'd3, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 3));   // STA
        add(0, 3'd3, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 3));
        add(0, 3'd3, 0, 1, ex(2, ARIR, 2'b00, 0, 0, 3));
        add(0, 3'd3, 0, 1, ex(3, WR, 2'b00, 0, 0, 3));
        add(0, 3'd5, 1, 1, ex(0, ARPC, 2'b00, 0, 0, 4));   // BZ taken
        add(0, 3'd5, 1, 1, ex(1, FETCH, 2'b00, 0, 0, 4));
        add(0, 3'd5, 1, 1, ex(2, PCL, 2'b00, 0, 0, 4));
        add(0, 3'd5, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 5));   // BZ not taken
        add(0, 3'd5, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 5));
        add(0, 3'd5, 0, 1, ex(2, NONE, 2'b00, 0, 0, 5));
        add(0, 3'd4, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 6));   // JMP
        add(0, 3'd4, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 6));
        add(1, 3'd4, 0, 1, ex(2, PCL, 2'b00, 0, 0, 6));    // start ignored
        add(0, 3'd6, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 7));   // CMA
        add(0, 3'd6, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 7));
        add(0, 3'd6, 0, 1, ex(2, ACL, 2'b11, 0, 0, 7));
        add(0, 3'd7, 0, 0, ex(0, ARPC, 2'b00, 0, 0, 8));   // HLT, 3 fetch waits
        add(0, 3'd7, 0, 0, ex(1, RD, 2'b00, 0, 0, 8));
        add(0, 3'd7, 0, 0, ex(1, RD, 2'b00, 0, 0, 8));
        add(0, 3'd7, 0, 0, ex(1, RD, 2'b00, 0, 0, 8));
        add(0, 3'd7, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 8));
        add(0, 3'd7, 0, 1, ex(2, NONE, 2'b00, 0, 0, 8));
        add(0, 3'd7, 0, 1, ex(7, NONE, 2'b00, 1, 0, 9));

        // Reset held
        step("reset0", 0, 0, 3'd0, 0, 0, ex(7, NONE, 2'b00, 0, 0, 0));
        step("reset1", 0, 1, 3'd0, 0, 1, ex(7, NONE, 2'b00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), 1, tbl[i].st, tbl[i].op, tbl[i].az,
                 tbl[i].mr, tbl[i].e);
        end

        // STA whose write never completes: 16 strobe cycles then abort.
        step("to_start", 1, 1, 3'd3, 0, 1, ex(7, NONE, 2'b00, 1, 0, 9));
        step("to_f0",    1, 0, 3'd3, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 9));
        step("to_f1",    1, 0, 3'd3, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 9));
        step("to_dec",   1, 0, 3'd3, 0, 1, ex(2, ARIR, 2'b00, 0, 0, 9));
        for (int i = 0; i < 16; i++) begin
            step($sformatf("to_e0_%0d", i), 1, 0, 3'd3, 0, 0,
                 ex(3, WR, 2'b00, 0, 0, 9));
        end
        step("to_idle",  1, 0, 3'd3, 0, 0, ex(7, NONE, 2'b00, 0, 1, 9));
        step("to_rest",  1, 1, 3'd0, 0, 1, ex(7, NONE, 2'b00, 0, 1, 9));
        step("to_clr",   1, 0, 3'd0, 0, 0, ex(0, ARPC, 2'b00, 0, 0, 9));

        // Ready on the last allowed wait cycle completes normally.
        for (int i = 0; i < 15; i++) begin
            step($sformatf("last_f1_%0d", i), 1, 0, 3'd0, 0, 0,
                 ex(1, RD, 2'b00, 0, 0, 9));
        end
        step("last_ok",  1, 0, 3'd0, 0, 1, ex(1, FETCH, 2'b00, 0, 0, 9));
        step("last_dec", 1, 0, 3'd0, 0, 1, ex(2, ARIR, 2'b00, 0, 0, 9));
        step("mid_e0",   1, 0, 3'd0, 0, 0, ex(3, RD, 2'b00, 0, 0, 9));

        // Reset dropped mid-E0 takes effect within the same cycle.
        step("mid_rst",  0, 0, 3'd0, 0, 0, ex(7, NONE, 2'b00, 0, 0, 0));

        // 256 JMPs: counter wraps back to zero.
        step("wrap_go",  1, 1, 3'd4, 0, 1, ex(7, NONE, 2'b00, 0, 0, 0));
        for (int i = 0; i < 256; i++) begin
            step($sformatf("wrap_f0_%0d", i), 1, 0, 3'd4, 0, 1,
                 ex(0, ARPC, 2'b00, 0, 0, 8'(i)));
            step($sformatf("wrap_f1_%0d", i), 1, 0, 3'd4, 0, 1,
                 ex(1, FETCH, 2'b00, 0, 0, 8'(i)));
            step($sformatf("wrap_dec_%0d", i), 1, 0, 3'd4, 0, 1,
                 ex(2, PCL, 2'b00, 0, 0, 8'(i)));
        end
        step("wrap_end", 1, 0, 3'd4, 0, 1, ex(0, ARPC, 2'b00, 0, 0, 8'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mano_control_sequencer.md
Name: mano_control_sequencer

Overview:
- Timing-and-control unit for the 8-bit accumulator computer; drives the fetch/decode/execute sequence of the AR, PC, IR, DR and ACC datapath and the shared memory.
- Produces the T-state count, register-load and memory strobes, and handles memory wait states with a timeout.
- Also provides run/halt status and a retired-instruction counter.
- Sits between the datapath (opcode, ACC-zero flag) and the memory (ready handshake).

Parameters:
- CNT_W, 8, width of insn_count (wraps modulo 2^CNT_W).
- WAIT_MAX, 15, maximum stall cycles tolerated on one memory access before abort (>=1).

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution; sampled only in IDLE.
- ir_opcode  in  3  IR[7:5]; valid from DEC onward.
- acc_zero  in  1  ACC==0 flag from datapath.
- mem_ready  in  1  memory completes current rd/wr this cycle.
- ar_load_pc  out  1  AR<-PC.
- ar_load_ir  out  1  AR<-IR address field.
- pc_inc  out  1  PC<-PC+1.
- pc_load  out  1  PC<-IR address field.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request (data = ACC).
- ir_load  out  1  IR<-memory data.
- dr_load  out  1  DR<-memory data.
- acc_load  out  1  ACC<-ALU result.
- acc_op  out  2  00 pass DR, 01 ACC+DR, 10 ACC&DR, 11 ~ACC.
- t_state  out  3  0..4 in F0..E1, 7 in IDLE.
- busy  out  1  1 when not IDLE.
- halted  out  1  sticky, HLT executed.
- bus_err  out  1  sticky, memory timeout.
- insn_count  out  CNT_W  instructions completed.

Behaviour:
- Reset (async, reset_n=0): state IDLE, wait counter 0, insn_count 0, halted 0, bus_err 0. All strobes 0, acc_op 00, t_state 7, busy 0. Asserting reset mid-instruction aborts it immediately.
- Registered elements: state, wait counter, halted, bus_err and insn_count. All strobes are combinational decode of state, ir_opcode, mem_ready and acc_zero.
- Opcodes:
  - 000 LDA, 001 ADD, 010 AND, 011 STA: memory-reference.
  - 100 JMP.
  - 101 BZ: branch if acc_zero.
  - 110 CMA.
  - 111 HLT.
- IDLE: if start=1, go to F0 and clear halted and bus_err. Otherwise stay.
- F0 (T0): ar_load_pc=1; go to F1.
- F1 (T1): mem_rd=1 while waiting. In the cycle with mem_ready=1: ir_load=1, pc_inc=1, go to DEC.
- DEC (T2):
  - LDA/ADD/AND/STA: ar_load_ir=1, go to E0.
  - JMP: pc_load=1, go to F0.
  - BZ: pc_load=acc_zero, go to F0.
  - CMA: acc_load=1, acc_op=11, go to F0.
  - HLT: set halted, go to IDLE.
- E0 (T3):
  - LDA/ADD/AND: mem_rd=1. On mem_ready: dr_load=1, go to E1.
  - STA: mem_wr=1. On mem_ready, go to F0.
- E1 (T4): acc_load=1, acc_op = 00 (LDA), 01 (ADD) or 10 (AND); go to F0.
- Wait handling:
  - The wait counter clears on entry to F1/E0 and increments each cycle mem_ready=0.
  - If mem_ready=0 while the counter equals WAIT_MAX, abort at that edge: go to IDLE, set bus_err. The strobe is therefore held WAIT_MAX+1 cycles.
  - mem_ready arriving on the last allowed cycle completes normally.
  - mem_ready is ignored outside F1/E0.
- insn_count increments by 1, with wrap, on every completed instruction: DEC->F0, DEC->IDLE (HLT), E0->F0 (STA), E1->F0. It is not incremented on timeout abort.
- Zero-wait latencies: LDA/ADD/AND 5 cycles, STA 4, JMP/BZ/CMA/HLT 3.
- start outside IDLE is ignored. mem_rd and mem_wr are never asserted together.

Test Plan:
1. Reset, then hold reset_n=0 -> all strobes 0, t_state=7, busy=0. Release, pulse start 1 cycle -> next cycle t_state=0, ar_load_pc=1, busy=1.
2. mem_ready tied 1, opcode 000 -> t_state sequence 0,1,2,3,4,0. dr_load at T3, acc_load with acc_op=00 at T4, insn_count 0->1. Opcode 001 -> acc_op=01 at T4.
3. Opcode 101: with acc_zero=1 -> pc_load=1 at T2, back to T0 next cycle. With acc_zero=0 -> pc_load=0. insn_count +1 each case.
4. mem_ready=0 for 3 cycles in F1 -> mem_rd high 4 cycles, t_state stays 1. ir_load/pc_inc high only in the 4th cycle.
5. WAIT_MAX=15, STA with mem_ready stuck 0 in E0 -> mem_wr high 16 cycles, then IDLE, bus_err=1, insn_count unchanged. Next start clears bus_err.
6. Opcode 111 -> halted=1, t_state=7 after T2, insn_count +1. Separately, drop reset_n mid-E0 -> same cycle IDLE, mem_rd=0, insn_count=0.
